execute_memory_skid_pipeline: RTL and testbench
===============================================

// Module: execute_memory_skid_pipeline
// PURPOSE
//  Parametrised EX/MEM pipeline register with valid/ready flow control, stall, flush and an optional skid entry.
//  Sits between ALU (execute) and data memory (memory) stages; lets MEM stall without losing EX results.
//  Full throughput in skid mode, with in_ready registered so the stall path is cut.
//  Bubbles (empty slots or flushed beats) always present all control bits as 0 to MEM.
// PARAMETERS
//  DATA_W   32  width of ALUResult and WriteData paths
//  REG_W     5  register-file address width (WriteReg)
//  PC_W     32  width of branch-target path (PCBranch_Result)
//  SKID_EN   1  1: 2-entry (main+skid), registered in_ready; 0: 1-entry, in_ready = !out_valid | out_ready (combinational)
// PORTS
//  clk               in   1       rising-edge clock
//  rst               in   1       asynchronous, active-high reset
//  flush             in   1       sync kill of all held and incoming beats (branch taken / exception)
//  in_valid          in   1       EX beat present
//  in_ready          out  1       register can accept a beat this cycle
//  RegWriteE         in   1       control: write register file
//  MemtoRegE         in   1       control: writeback selects memory data
//  MemWriteE         in   1       control: store
//  BranchE           in   1       control: branch instruction
//  ALUResultE        in   DATA_W  ALU result / memory address
//  ZeroFlagE         in   1       ALU zero flag
//  WriteDataE        in   DATA_W  store data
//  WriteRegE         in   REG_W   destination register
//  PCBranch_ResultE  in   PC_W    branch target
//  out_valid         out  1       MEM beat present
//  out_ready         in   1       MEM consumes beat this cycle
//  RegWriteM..PCBranch_ResultM  out  (same widths as E)  registered copies of the E fields
// BEHAVIOUR
//  - Accept = in_valid & in_ready; Consume = out_valid & out_ready; evaluated at posedge clk.
//  - Latency: accepted beat appears on M outputs with out_valid=1 on the next cycle (1 cycle).
//  - Ordering strictly FIFO; no beat dropped or duplicated except by flush.
//  - Skid mode, entries main (drives outputs) and skid; in_ready = !skid_valid (registered):
//      main empty, Accept                 -> beat to main
//      main full, Consume, skid empty     -> beat (if Accept) to main, else main empties
//      main full, Consume, skid full      -> skid to main, skid empties (no Accept possible)
//      main full, !Consume, Accept        -> beat to skid; in_ready=0 next cycle
//  - SKID_EN=0: single entry; Accept loads main; Consume without Accept empties it.
//  - Control gating: RegWriteM, MemtoRegM, MemWriteM, BranchM are 0 whenever out_valid=0 (registered, not gated comb).
//  - Data fields (ALUResultM, ZeroFlagM, WriteDataM, WriteRegM, PCBranch_ResultM) hold last value when empty.
//  - flush=1: next cycle out_valid=0, skid empty, control M outputs 0, in_ready=1; same-cycle E beat discarded
//    even if in_valid & in_ready; flush overrides Accept/Consume; a Consume in the flush cycle still completes.
//  - rst (async, any time incl. mid-transfer): out_valid=0, all M outputs 0, skid empty, in_ready=1 while asserted
//    and after release; no beat emitted from pre-reset state.
//  - No arithmetic; all fields copied bit-exact, widths per parameters.
// TESTING
//  1 Streaming: out_ready=1, 8 beats ALUResultE=1..8 back-to-back -> ALUResultM=1..8 one cycle later, in_ready never 0.
//  2 Stall: beats A=0x10,B=0x20 accepted, out_ready=0 3 cycles -> B in skid, in_ready=0; release -> A then B, none lost.
//  3 Flush: main=0x10 (MemWriteE=1), skid=0x20, flush=1 with in_valid beat 0x30 -> next cycle out_valid=0,
//    MemWriteM=0, in_ready=1; 0x30 never appears.
//  4 Bubble: in_valid=0 after beat RegWriteE=1 WriteRegE=5 consumed -> out_valid=0, RegWriteM=0, WriteRegM holds 5.
//  5 Async reset mid-stall with both entries full -> outputs 0 immediately, in_ready=1, no beat after release.
//  6 SKID_EN=0: out_ready=0 with main full -> in_ready=0 same cycle; out_ready=1 and in_valid -> pass-through each cycle.

Source files
------------

// File: rtl/execute_memory_skid_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_memory_skid_pipeline_if
// Purpose  : EX->MEM beat bundle: valid/ready handshake plus the E-side and
//            M-side copies of the pipeline fields.
// Revision : 1.0 - initial release
// ============================================================================
interface execute_memory_skid_pipeline_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic              BranchE;
  logic [DATA_W-1:0] ALUResultE;
  logic              ZeroFlagE;
  logic [DATA_W-1:0] WriteDataE;
  logic [REG_W-1:0]  WriteRegE;
  logic [PC_W-1:0]   PCBranch_ResultE;

  logic              out_valid;
  logic              out_ready;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic              BranchM;
  logic [DATA_W-1:0] ALUResultM;
  logic              ZeroFlagM;
  logic [DATA_W-1:0] WriteDataM;
  logic [REG_W-1:0]  WriteRegM;
  logic [PC_W-1:0]   PCBranch_ResultM;

  modport slave (
    input  in_valid, RegWriteE, MemtoRegE, MemWriteE, BranchE,
           ALUResultE, ZeroFlagE, WriteDataE, WriteRegE, PCBranch_ResultE,
           out_ready,
    output in_ready, out_valid, RegWriteM, MemtoRegM, MemWriteM, BranchM,
           ALUResultM, ZeroFlagM, WriteDataM, WriteRegM, PCBranch_ResultM
  );

  modport master (
    output in_valid, RegWriteE, MemtoRegE, MemWriteE, BranchE,
           ALUResultE, ZeroFlagE, WriteDataE, WriteRegE, PCBranch_ResultE,
           out_ready,
    input  in_ready, out_valid, RegWriteM, MemtoRegM, MemWriteM, BranchM,
           ALUResultM, ZeroFlagM, WriteDataM, WriteRegM, PCBranch_ResultM
  );
endinterface
`default_nettype wire

// File: rtl/execute_memory_skid_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : execute_memory_skid_pipeline
// Purpose  : EX/MEM pipeline register with valid/ready flow control, flush and
//            an optional skid entry that registers in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module execute_memory_skid_pipeline #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  execute_memory_skid_pipeline_if.slave bus
);

  localparam int c_CTRL_W    = 4;
  localparam int c_PAYLOAD_W = 2 * DATA_W + 1 + REG_W + PC_W;

  logic [c_CTRL_W-1:0]    w_inCtrl;
  logic [c_PAYLOAD_W-1:0] w_inData;
  logic                   w_inReady;
  logic                   w_accept;
  logic                   w_consume;
  logic                   w_mainFromIn;
  logic                   w_mainFromSkid;
  logic                   w_mainDrain;
  logic                   w_toSkid;

  logic                   w_skidValid;
  logic [c_CTRL_W-1:0]    w_skidCtrl;
  logic [c_PAYLOAD_W-1:0] w_skidData;

  logic                   r_mainValid;
  logic [c_CTRL_W-1:0]    r_mainCtrl;
  logic [c_PAYLOAD_W-1:0] r_mainData;

  assign w_inCtrl = {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.BranchE};
  assign w_inData = {bus.ALUResultE, bus.ZeroFlagE, bus.WriteDataE,
                     bus.WriteRegE, bus.PCBranch_ResultE};

  assign w_accept  = bus.in_valid & w_inReady;
  assign w_consume = r_mainValid & bus.out_ready;

  // Main refills from skid first so ordering stays FIFO; the skid only ever
  // holds a beat while main is also full.
  assign w_mainFromSkid = w_skidValid & w_consume;
  assign w_mainFromIn   = w_accept & (~r_mainValid | (w_consume & ~w_skidValid));
  assign w_mainDrain    = w_consume & ~w_mainFromSkid & ~w_mainFromIn;
  assign w_toSkid       = w_accept & r_mainValid & ~w_consume;

  // Control bits are cleared whenever main empties so bubbles present zeros
  // straight from the flops; the data payload simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mainValid <= 1'b0;
      r_mainCtrl  <= '0;
      r_mainData  <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_mainCtrl  <= '0;
    end else if (w_mainFromSkid) begin
      r_mainValid <= 1'b1;
      r_mainCtrl  <= w_skidCtrl;
      r_mainData  <= w_skidData;
    end else if (w_mainFromIn) begin
      r_mainValid <= 1'b1;
      r_mainCtrl  <= w_inCtrl;
      r_mainData  <= w_inData;
    end else if (w_mainDrain) begin
      r_mainValid <= 1'b0;
      r_mainCtrl  <= '0;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic                   r_skidValid;
      logic [c_CTRL_W-1:0]    r_skidCtrl;
      logic [c_PAYLOAD_W-1:0] r_skidData;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_skidValid <= 1'b0;
          r_skidCtrl  <= '0;
          r_skidData  <= '0;
        end else if (flush) begin
          r_skidValid <= 1'b0;
          r_skidCtrl  <= '0;
        end else if (w_toSkid) begin
          r_skidValid <= 1'b1;
          r_skidCtrl  <= w_inCtrl;
          r_skidData  <= w_inData;
        end else if (w_mainFromSkid) begin
          r_skidValid <= 1'b0;
          r_skidCtrl  <= '0;
        end
      end

      // Ready depends only on a flop, cutting the MEM stall path.
      assign w_inReady   = ~r_skidValid;
      assign w_skidValid = r_skidValid;
      assign w_skidCtrl  = r_skidCtrl;
      assign w_skidData  = r_skidData;
    end else begin : g_noSkid
      assign w_inReady   = ~r_mainValid | bus.out_ready;
      assign w_skidValid = 1'b0;
      assign w_skidCtrl  = '0;
      assign w_skidData  = '0;
    end
  endgenerate

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_mainValid;
  assign {bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.BranchM} = r_mainCtrl;
  assign {bus.ALUResultM, bus.ZeroFlagM, bus.WriteDataM,
          bus.WriteRegM, bus.PCBranch_ResultM} = r_mainData;

endmodule
`default_nettype wire

// File: tb/tb_execute_memory_skid_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_memory_skid_pipeline
// Purpose  : Self-checking bench for the EX/MEM skid register, both modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_memory_skid_pipeline;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic        br;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [31:0] pc;
  } beat_t;

  typedef struct {
    logic        inValid;
    logic        outReady;
    logic [31:0] alu;
    logic        expInReady;
    logic        expOutValid;
    logic [31:0] expAlu;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  beat_t curS, curN, outS, outN;
  beat_t qS[$];
  beat_t qN[$];
  beat_t b;
  vec_t  vecs[16];

  always #5 clk = ~clk;

  execute_memory_skid_pipeline_if busS ();
  execute_memory_skid_pipeline_if busN ();

  execute_memory_skid_pipeline #(.SKID_EN(1'b1)) u_dutSkid (
    .clk(clk), .rst(rst), .flush(flush), .bus(busS)
  );
  execute_memory_skid_pipeline #(.SKID_EN(1'b0)) u_dutNoSkid (
    .clk(clk), .rst(rst), .flush(flush), .bus(busN)
  );

  assign outS = {busS.RegWriteM, busS.MemtoRegM, busS.MemWriteM, busS.BranchM,
                 busS.ALUResultM, busS.ZeroFlagM, busS.WriteDataM,
                 busS.WriteRegM, busS.PCBranch_ResultM};
  assign outN = {busN.RegWriteM, busN.MemtoRegM, busN.MemWriteM, busN.BranchM,
                 busN.ALUResultM, busN.ZeroFlagM, busN.WriteDataM,
                 busN.WriteRegM, busN.PCBranch_ResultM};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mkBeat(input logic [31:0] alu);
    beat_t r;
    r.rw   = alu[0];
    r.mtr  = alu[1];
    r.mw   = alu[2];
    r.br   = alu[3];
    r.alu  = alu;
    r.zero = (alu == 32'd0);
    r.wd   = alu ^ 32'hA5A5_0F0F;
    r.wr   = alu[4:0] ^ 5'h1B;
    r.pc   = {alu[29:0], 2'b00} + 32'h0000_1000;
    return r;
  endfunction

  function automatic vec_t mv(input logic v, input logic r, input logic [31:0] a,
                              input logic er, input logic ev, input logic [31:0] ea);
    vec_t x;
    x.inValid = v; x.outReady = r; x.alu = a;
    x.expInReady = er; x.expOutValid = ev; x.expAlu = ea;
    return x;
  endfunction

  task automatic driveS(input beat_t bt, input logic v, input logic r);
    curS = bt;
    busS.in_valid = v;        busS.out_ready = r;
    busS.RegWriteE = bt.rw;   busS.MemtoRegE = bt.mtr;
    busS.MemWriteE = bt.mw;   busS.BranchE = bt.br;
    busS.ALUResultE = bt.alu; busS.ZeroFlagE = bt.zero;
    busS.WriteDataE = bt.wd;  busS.WriteRegE = bt.wr;
    busS.PCBranch_ResultE = bt.pc;
  endtask

  task automatic driveN(input beat_t bt, input logic v, input logic r);
    curN = bt;
    busN.in_valid = v;        busN.out_ready = r;
    busN.RegWriteE = bt.rw;   busN.MemtoRegE = bt.mtr;
    busN.MemWriteE = bt.mw;   busN.BranchE = bt.br;
    busN.ALUResultE = bt.alu; busN.ZeroFlagE = bt.zero;
    busN.WriteDataE = bt.wd;  busN.WriteRegE = bt.wr;
    busN.PCBranch_ResultE = bt.pc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: consumed beats are compared first, then flush kills held
  // beats, then accepted stimulus is queued.
  always @(negedge clk) begin
    if (rst) begin
      qS.delete();
    end else begin
      if (busS.out_valid && busS.out_ready) begin
        if (qS.size() == 0) chk("sbS_unexpected_beat", 1, 0);
        else chk("sbS_beat", outS, qS.pop_front());
      end
      if (!busS.out_valid)
        chk("sbS_bubble_ctrl", {busS.RegWriteM, busS.MemtoRegM, busS.MemWriteM, busS.BranchM}, 0);
      if (flush) qS.delete();
      else if (busS.in_valid && busS.in_ready) qS.push_back(curS);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qN.delete();
    end else begin
      if (busN.out_valid && busN.out_ready) begin
        if (qN.size() == 0) chk("sbN_unexpected_beat", 1, 0);
        else chk("sbN_beat", outN, qN.pop_front());
      end
      if (!busN.out_valid)
        chk("sbN_bubble_ctrl", {busN.RegWriteM, busN.MemtoRegM, busN.MemWriteM, busN.BranchM}, 0);
      if (flush) qN.delete();
      else if (busN.in_valid && busN.in_ready) qN.push_back(curN);
    end
  end

  initial begin
    // Streaming 1..8, then a three-cycle stall with A=0x10 / B=0x20.
    vecs[0] = mv(1, 1, 32'd1, 1, 0, 32'd0);
    for (int i = 1; i < 8; i++) vecs[i] = mv(1, 1, i + 1, 1, 1, i);
    vecs[8]  = mv(0, 1, 32'd0,  1, 1, 32'd8);
    vecs[9]  = mv(0, 1, 32'd0,  1, 0, 32'd8);
    vecs[10] = mv(1, 0, 32'h10, 1, 0, 32'd8);
    vecs[11] = mv(1, 0, 32'h20, 1, 1, 32'h10);
    vecs[12] = mv(0, 0, 32'd0,  0, 1, 32'h10);
    vecs[13] = mv(0, 1, 32'd0,  0, 1, 32'h10);
    vecs[14] = mv(0, 1, 32'd0,  1, 1, 32'h20);
    vecs[15] = mv(0, 1, 32'd0,  1, 0, 32'h20);

    rst = 1'b1;
    flush = 1'b0;
    driveS(mkBeat(32'd0), 0, 0);
    driveN(mkBeat(32'd0), 0, 0);
    #3;
    chk("rst_outValid", busS.out_valid, 0);
    chk("rst_inReady", busS.in_ready, 1);
    chk("rst_outputs", outS, 0);
    chk("rstN_inReady", busN.in_ready, 1);
    nextCycle();
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      driveS(mkBeat(vecs[i].alu), vecs[i].inValid, vecs[i].outReady);
      @(negedge clk);
      chk($sformatf("vec%0d_inReady", i), busS.in_ready, vecs[i].expInReady);
      chk($sformatf("vec%0d_outValid", i), busS.out_valid, vecs[i].expOutValid);
      chk($sformatf("vec%0d_alu", i), busS.ALUResultM, vecs[i].expAlu);
      nextCycle();
    end

    // Flush with main=0x10 (store) and skid=0x20 while 0x30 is offered.
    b = mkBeat(32'h10);
    b.mw = 1'b1;
    driveS(b, 1, 0);
    nextCycle();
    driveS(mkBeat(32'h20), 1, 0);
    @(negedge clk);
    chk("flush_pre_alu", busS.ALUResultM, 32'h10);
    nextCycle();
    flush = 1'b1;
    driveS(mkBeat(32'h30), 1, 0);
    @(negedge clk);
    chk("flush_pre_memWrite", busS.MemWriteM, 1);
    chk("flush_pre_inReady", busS.in_ready, 0);
    nextCycle();
    flush = 1'b0;
    driveS(mkBeat(32'h30), 0, 1);
    @(negedge clk);
    chk("flush_outValid", busS.out_valid, 0);
    chk("flush_memWrite", busS.MemWriteM, 0);
    chk("flush_inReady", busS.in_ready, 1);
    nextCycle();
    @(negedge clk);
    chk("flush_stays_empty", busS.out_valid, 0);
    nextCycle();

    // Flush discards a beat that is accepted in the same cycle.
    flush = 1'b1;
    driveS(mkBeat(32'h40), 1, 1);
    nextCycle();
    flush = 1'b0;
    driveS(mkBeat(32'h40), 0, 1);
    @(negedge clk);
    chk("flush_same_cycle_beat", busS.out_valid, 0);
    nextCycle();

    // Bubble after a register-writing beat: control clears, WriteReg holds.
    b = mkBeat(32'h70);
    b.rw = 1'b1;
    b.wr = 5'd5;
    driveS(b, 1, 1);
    nextCycle();
    driveS(mkBeat(32'd0), 0, 1);
    @(negedge clk);
    chk("bubble_pre_regWrite", busS.RegWriteM, 1);
    chk("bubble_pre_writeReg", busS.WriteRegM, 5);
    nextCycle();
    @(negedge clk);
    chk("bubble_outValid", busS.out_valid, 0);
    chk("bubble_regWrite", busS.RegWriteM, 0);
    chk("bubble_writeReg_hold", busS.WriteRegM, 5);
    nextCycle();

    // Asynchronous reset mid-stall with main and skid both full.
    driveS(mkBeat(32'h60), 1, 0);
    nextCycle();
    driveS(mkBeat(32'h61), 1, 0);
    nextCycle();
    driveS(mkBeat(32'd0), 0, 0);
    @(negedge clk);
    chk("arst_pre_full", {busS.out_valid, busS.in_ready}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_outValid", busS.out_valid, 0);
    chk("arst_outputs", outS, 0);
    chk("arst_inReady", busS.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    driveS(mkBeat(32'd0), 0, 1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      @(negedge clk);
      chk("arst_no_beat_after", busS.out_valid, 0);
      chk("arst_inReady_after", busS.in_ready, 1);
    end
    nextCycle();

    // Single-entry mode: combinational in_ready and pass-through.
    driveN(mkBeat(32'h50), 1, 0);
    @(negedge clk);
    chk("noskid_empty_ready", busN.in_ready, 1);
    nextCycle();
    driveN(mkBeat(32'h51), 1, 0);
    @(negedge clk);
    chk("noskid_stall_ready", busN.in_ready, 0);
    chk("noskid_hold_alu", busN.ALUResultM, 32'h50);
    nextCycle();
    driveN(mkBeat(32'h51), 1, 1);
    #1;
    chk("noskid_comb_ready", busN.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      driveN(mkBeat(32'h52 + i), 1, 1);
      @(negedge clk);
      chk($sformatf("noskid_pass%0d_valid", i), busN.out_valid, 1);
      chk($sformatf("noskid_pass%0d_alu", i), busN.ALUResultM, 32'h51 + i);
    end
    nextCycle();
    driveN(mkBeat(32'd0), 0, 1);
    @(negedge clk);
    chk("noskid_last_alu", busN.ALUResultM, 32'h54);
    nextCycle();
    @(negedge clk);
    chk("noskid_drained", busN.out_valid, 0);
    nextCycle();

    chk("sbS_empty_at_end", qS.size(), 0);
    chk("sbN_empty_at_end", qN.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
